prmcu_uart_rx: RTL
==================

Name: prmcu_uart_rx

Overview:
- Standalone UART receiver that deserialises the rx_i line into parallel bytes. Supports configurable data width, parity and stop bits.
- Presents each received byte on a valid/ready output with a one-entry holding register.
- Sits directly upstream of the UART command/LED logic in the hardware-test top and replaces ad-hoc bit sampling there.
- Reports framing, parity and overrun errors as single-cycle pulses.

Parameters:
- N_BITS, 8, data bits per frame (5..9), sent LSB first.
- CLKS_PER_BIT, 87, clk cycles per bit period (10 MHz / 115200 baud); minimum 4.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- N_STOP, 1, number of stop bits checked (1 or 2).

Ports:
- clk  in  1  system clock, sole clock domain.
- rst  in  1  synchronous, active-low reset.
- rx_i  in  1  asynchronous serial input; idles high.
- dat_o  out  N_BITS  received data; valid only while vld_o=1.
- vld_o  out  1  dat_o holds an unconsumed byte.
- rdy_i  in  1  consumer accepts dat_o when vld_o&rdy_i at a rising edge of clk.
- parity_err_o  out  1  one-cycle pulse when a frame is discarded for a parity mismatch.
- frame_err_o  out  1  one-cycle pulse when a frame is discarded because a stop bit was sampled 0.
- overrun_o  out  1  one-cycle pulse when a good frame is dropped because the holding register was full.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 at a clk edge): FSM to IDLE; synchroniser flops to 1; dat_o=0; vld_o=0; all error pulses 0; busy_o=0. Reset mid-frame abandons the frame; no byte or error is reported.
- Input sync: rx_i passes through 2 flops. All decisions use the synchronised value rxs. This adds 2 cycles of fixed input latency.
- Single bit-timer counter, width clog2(CLKS_PER_BIT).
- IDLE: when rxs=0, load timer with CLKS_PER_BIT/2 (floor) and go to START.
- START: on timer expiry, sample rxs.
  - rxs=1: false start; return to IDLE with no pulse.
  - rxs=0: reload timer with CLKS_PER_BIT and go to DATA.
- DATA: on each expiry, shift rxs into the shift register at bit index k (LSB first) and reload the timer. After N_BITS samples:
  - go to PARITY if PARITY!=0;
  - otherwise go to STOP.
- PARITY: sample one bit.
  - Even: XOR of data bits and parity bit must be 0.
  - Odd: that XOR must be 1.
  - Record the result and go to STOP.
- STOP: sample N_STOP bits, one per bit period. Any 0 sample flags a framing error.
- Frame end, evaluated at the last stop-bit sample cycle:
  - Framing error (takes priority over parity): pulse frame_err_o next cycle, drop the byte, go to WAIT_HIGH.
  - Else parity error: pulse parity_err_o next cycle, drop the byte, go to IDLE.
  - Else commit the byte.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents break conditions from retriggering reception.
- Commit rules (outcome is visible on the cycle after the last stop-bit sample):
  - vld_o=0: load dat_o; vld_o=1 on the next cycle.
  - vld_o=1 and rdy_i=1 in the same cycle: the old byte is consumed, the new byte loads, vld_o stays 1, no overrun.
  - vld_o=1 and rdy_i=0: keep the old byte, drop the new one, pulse overrun_o.
- Handshake:
  - vld_o falls the cycle after vld_o&rdy_i when no commit coincides.
  - dat_o is stable while vld_o=1.
  - rdy_i is ignored while vld_o=0.
- Sample timing: sampling is mid-bit. Back-to-back frames must be accepted: after the final stop sample the FSM returns to IDLE, so a start edge half a bit later is caught.
- Latency: vld_o rises 1 clk after the final stop-bit sample, i.e. about (1 + N_BITS + parity + N_STOP − 0.5) bit periods + 3 clk after the start edge at rx_i.

Test Plan:
- Default params; drive 0x54 (start, 0,0,1,0,1,0,1,0, stop) at 87 clk/bit with rdy_i=1 -> exactly one vld_o cycle with dat_o=0x54; no error pulses.
- 100 back-to-back random bytes, with 0x54 at every index multiple of 10, rdy_i=1 -> all 100 bytes received in order; zero errors.
- 20-clk low glitch on an idle line -> no vld_o, no error pulses, busy_o returns to 0 within 44 clk.
- 0xA5 sent with stop bit 0 -> frame_err_o pulses once, no vld_o; the FSM stays in WAIT_HIGH until the line goes high; the next valid 0x3C is received.
- PARITY=2; send 0x07 with parity bit 0 -> parity_err_o pulses once, no vld_o. Send 0x07 with parity bit 1 -> dat_o=0x07.
- Two further cases:
  - rdy_i=0; send 0x11 then 0x22 -> dat_o stays 0x11 and overrun_o pulses once at the 0x22 commit.
  - rst=0 in the middle of DATA, then released; send 0x5A -> only 0x5A is observed.

Source files
------------

// File: rtl/prmcu_uart_rx.sv
// prmcu_uart_rx: mid-bit sampling UART receiver with a one-entry
// valid/ready holding register and single-cycle error pulses.
module prmcu_uart_rx #(
  parameter int N_BITS       = 8,
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY       = 0,
  parameter int N_STOP       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  output logic [N_BITS-1:0] dat_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAITH
  } state_t;

  localparam int TW = $clog2(CLKS_PER_BIT);
  // Timer counts down to zero, so loads are one less than the period
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] LAST_D = 4'(N_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(N_STOP - 1);

  state_t            state;
  logic              s1;
  logic              rxs;
  logic [TW-1:0]     tmr;
  logic [3:0]        cnt;
  logic [N_BITS-1:0] sh;
  logic              ferr;
  logic              pbad;
  logic              tmr_exp;
  logic              stop_bad;
  logic              par_calc;

  assign tmr_exp  = (tmr == '0);
  assign stop_bad = ferr | ~rxs;
  assign par_calc = (PARITY == 1) ? ~(^sh ^ rxs)
                                  : (^sh ^ rxs);
  assign busy_o   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      s1           <= 1'b1;
      rxs          <= 1'b1;
      tmr          <= '0;
      cnt          <= '0;
      sh           <= '0;
      ferr         <= 1'b0;
      pbad         <= 1'b0;
      dat_o        <= '0;
      vld_o        <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      s1           <= rx_i;
      rxs          <= s1;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      if (vld_o && rdy_i) vld_o <= 1'b0;
      if (!tmr_exp) tmr <= tmr - 1'b1;
      unique case (state)
        S_IDLE: begin
          if (!rxs) begin
            tmr   <= T_HALF;
            state <= S_START;
          end
        end
        S_START: begin
          if (tmr_exp) begin
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              tmr   <= T_FULL;
              cnt   <= '0;
              ferr  <= 1'b0;
              pbad  <= 1'b0;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (tmr_exp) begin
            sh  <= {rxs, sh[N_BITS-1:1]};
            tmr <= T_FULL;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_D) begin
              cnt   <= '0;
              state <= (PARITY != 0) ? S_PAR : S_STOP;
            end
          end
        end
        S_PAR: begin
          if (tmr_exp) begin
            pbad  <= par_calc;
            tmr   <= T_FULL;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (tmr_exp) begin
            ferr <= stop_bad;
            tmr  <= T_FULL;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_S) begin
              if (stop_bad) begin
                frame_err_o <= 1'b1;
                state       <= S_WAITH;
              end else if (pbad) begin
                parity_err_o <= 1'b1;
                state        <= S_IDLE;
              end else begin
                state <= S_IDLE;
                if (!vld_o || rdy_i) begin
                  dat_o <= sh;
                  vld_o <= 1'b1;
                end else begin
                  overrun_o <= 1'b1;
                end
              end
            end
          end
        end
        // Hold off a break until the line idles again
        S_WAITH: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
